// File: rtl/vcb_mod_updown.sv
// Modulo-MODULUS up/down binary counter with clock enable, sync clear, parallel load,
// cascade outputs (TC/CEO) and a registered one-cycle wrap pulse.
module vcb_mod_updown #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             r,
   input  logic             ce,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             up,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             CEO,
   output logic             WRAP
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             at_max, at_zero;
   logic [WIDTH-1:0] load_val;

   assign at_max  = (count_q == MaxVal);
   assign at_zero = (count_q == '0);

   // Out-of-range load values saturate so Q can never leave 0..MODULUS-1.
   assign load_val = (d > MaxVal) ? MaxVal : d;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (ld) begin
         count_d = load_val;
      end else if (ce) begin
         if (up) begin
            if (at_max) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (at_zero) begin
               count_d = MaxVal;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign Q    = count_q;
   assign WRAP = wrap_q;
   assign TC   = up ? at_max : at_zero;
   assign CEO  = ce & TC;

endmodule

// File: tb/tb_vcb_mod_updown.sv
// Directed self-checking bench for vcb_mod_updown: mod-10 counting, down count, load clamp,
// priority, async reset, enable gating on a mod-16 stage and a two-stage BCD cascade.
module tb_vcb_mod_updown;

   logic clk;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Instance A: WIDTH 4, MODULUS 10
   logic       r_a, ce_a, clr_a, ld_a, up_a;
   logic [3:0] d_a, q_a;
   logic       tc_a, ceo_a, wrap_a;

   // Instance B: WIDTH 4, MODULUS 16
   logic       r_bc, ce_b, up_b;
   logic [3:0] q_b;
   logic       tc_b, ceo_b, wrap_b;

   // Cascade: lo and hi, both MODULUS 10
   logic       ce_c;
   logic [3:0] q_lo, q_hi;
   logic       tc_lo, ceo_lo, wrap_lo, tc_hi, ceo_hi, wrap_hi;

   logic       zero = 1'b0;
   logic       one  = 1'b1;
   logic [3:0] zero4 = 4'd0;

   vcb_mod_updown #(.WIDTH(4), .MODULUS(10)) u_a (
      .clk(clk), .r(r_a), .ce(ce_a), .clr(clr_a), .ld(ld_a), .d(d_a), .up(up_a),
      .Q(q_a), .TC(tc_a), .CEO(ceo_a), .WRAP(wrap_a)
   );

   vcb_mod_updown #(.WIDTH(4), .MODULUS(16)) u_b (
      .clk(clk), .r(r_bc), .ce(ce_b), .clr(zero), .ld(zero), .d(zero4), .up(up_b),
      .Q(q_b), .TC(tc_b), .CEO(ceo_b), .WRAP(wrap_b)
   );

   vcb_mod_updown #(.WIDTH(4), .MODULUS(10)) u_lo (
      .clk(clk), .r(r_bc), .ce(ce_c), .clr(zero), .ld(zero), .d(zero4), .up(one),
      .Q(q_lo), .TC(tc_lo), .CEO(ceo_lo), .WRAP(wrap_lo)
   );

   vcb_mod_updown #(.WIDTH(4), .MODULUS(10)) u_hi (
      .clk(clk), .r(r_bc), .ce(ceo_lo), .clr(zero), .ld(zero), .d(zero4), .up(one),
      .Q(q_hi), .TC(tc_hi), .CEO(ceo_hi), .WRAP(wrap_hi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_q;
      r_a = 1'b0; r_bc = 1'b0;
      ce_a = 1'b1; clr_a = 1'b0; ld_a = 1'b0; up_a = 1'b1; d_a = 4'd0;
      ce_b = 1'b0; up_b = 1'b1; ce_c = 1'b0;

      // Reset state, including combinational TC/CEO under reset
      #2;
      check("rst_q", q_a, 0);
      check("rst_wrap", wrap_a, 0);
      check("rst_tc_up", tc_a, 0);
      check("rst_ceo_up", ceo_a, 0);
      up_a = 1'b0;
      #1;
      check("rst_tc_dn", tc_a, 1);
      check("rst_ceo_dn", ceo_a, 1);
      up_a = 1'b1;
      tick();
      r_a = 1'b1; r_bc = 1'b1;
      #1;
      check("start_q", q_a, 0);

      // Mod-10 up count for 25 clocks
      for (int k = 1; k <= 25; k++) begin
         tick();
         exp_q = k % 10;
         check("up_q", q_a, exp_q);
         check("up_tc", tc_a, (exp_q == 9));
         check("up_ceo", ceo_a, (exp_q == 9));
         check("up_wrap", wrap_a, (exp_q == 0));
      end

      // Down count from a loaded 3
      up_a = 1'b0; ce_a = 1'b0; ld_a = 1'b1; d_a = 4'd3;
      tick();
      check("dn_ld_q", q_a, 3);
      check("dn_ld_tc", tc_a, 0);
      ld_a = 1'b0; ce_a = 1'b1;
      begin
         int exp_dn [5] = '{2, 1, 0, 9, 8};
         for (int k = 0; k < 5; k++) begin
            tick();
            check("dn_q", q_a, exp_dn[k]);
            check("dn_tc", tc_a, (exp_dn[k] == 0));
            check("dn_wrap", wrap_a, (exp_dn[k] == 9));
         end
      end

      // Direction change moves TC to the other terminal at once
      ld_a = 1'b1; d_a = 4'd0; ce_a = 1'b0;
      tick();
      ld_a = 1'b0;
      check("dir_tc_dn", tc_a, 1);
      up_a = 1'b1;
      #1;
      check("dir_tc_up", tc_a, 0);

      // Load clamp, load at terminal with ce, clear priority, hold
      ld_a = 1'b1; d_a = 4'd12;
      tick();
      check("clamp_q", q_a, 9);
      check("clamp_tc", tc_a, 1);
      ce_a = 1'b1; d_a = 4'd5;
      tick();
      check("ld_term_q", q_a, 5);
      check("ld_term_wrap", wrap_a, 0);
      clr_a = 1'b1;
      tick();
      check("clr_pri_q", q_a, 0);
      check("clr_pri_wrap", wrap_a, 0);
      clr_a = 1'b0; d_a = 4'd7;
      tick();
      check("ld_ce_q", q_a, 7);
      ld_a = 1'b0; ce_a = 1'b0;
      tick();
      tick();
      check("hold_q", q_a, 7);
      check("hold_wrap", wrap_a, 0);

      // Asynchronous reset mid-cycle at Q=6
      ld_a = 1'b1; d_a = 4'd6;
      tick();
      check("pre_rst_q", q_a, 6);
      ld_a = 1'b0; ce_a = 1'b1;
      #3;
      r_a = 1'b0;
      #1;
      check("async_q", q_a, 0);
      tick();
      tick();
      check("async_hold_q", q_a, 0);
      r_a = 1'b1;
      tick();
      check("post_rst_q", q_a, 1);

      // Enable gating on the mod-16 stage: 7 clocks low, 1 clock high
      exp_q = 0;
      for (int p = 0; p < 17; p++) begin
         for (int j = 0; j < 7; j++) tick();
         check("gate_hold_q", q_b, exp_q);
         check("gate_ceo_lo", ceo_b, 0);
         ce_b = 1'b1;
         #1;
         check("gate_ceo_hi", ceo_b, (exp_q == 15));
         tick();
         ce_b = 1'b0;
         exp_q = (exp_q + 1) % 16;
         check("gate_q", q_b, exp_q);
         check("gate_wrap", wrap_b, (exp_q == 0));
      end

      // Two-stage BCD cascade for 120 counted clocks
      check("casc_start", {q_hi, q_lo}, 8'h00);
      ce_c = 1'b1;
      for (int k = 1; k <= 120; k++) begin
         logic [7:0] bcd;
         tick();
         bcd = {4'((k % 100) / 10), 4'(k % 10)};
         check("casc_bcd", {q_hi, q_lo}, bcd);
         check("casc_hi_term", tc_hi & ceo_hi, ((k % 100) == 99));
      end
      ce_c = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
